// File: rtl/rx_memory_control.sv
// rx_memory_control: receive-side segment parser and VRAM writer.
// Parses the segment header from a de-framed payload byte stream, packs
// R,G,B bytes into 24-bit pixels, writes them to VRAM at startaddr+index,
// and tracks which segments of the current frame have been committed so
// that redundant copies of an already-good segment are dropped.
module rx_memory_control #(
  parameter int SEGMENT_NUMBER_MAX = 150,
  parameter int PAYLOAD_PIXELS     = 479,
  parameter int MAX_VRAMADDR       = 57600
) (
  input  logic        clk125MHz,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic        rx_crc_ok,
  input  logic [7:0]  redundancy,
  output logic        vram_we,
  output logic [23:0] vram_addr,
  output logic [23:0] vram_din,
  output logic        seg_commit,
  output logic        dup_drop,
  output logic        frame_done,
  output logic [15:0] committed_count
);

  localparam int SEG_IDX_W = $clog2(SEGMENT_NUMBER_MAX);
  localparam int PIX_CNT_W = $clog2(PAYLOAD_PIXELS + 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PIX,
    DROP
  } state_t;

  // Packet parser state
  state_t                 state_q,   state_d;
  logic [2:0]             hdr_cnt_q, hdr_cnt_d;
  logic [7:0]             txid_q,    txid_d;
  logic [15:0]            seg_q,     seg_d;
  logic [23:0]            start_q,   start_d;
  logic [1:0]             phase_q,   phase_d;
  logic [7:0]             r_q,       r_d;
  logic [7:0]             g_q,       g_d;
  logic [23:0]            pixaddr_q, pixaddr_d;
  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;

  // Registered outputs
  logic                   vram_we_q,   vram_we_d;
  logic [23:0]            vram_addr_q, vram_addr_d;
  logic [23:0]            vram_din_q,  vram_din_d;
  logic                   dup_drop_q,  dup_drop_d;
  logic                   seg_commit_q, seg_commit_d;
  logic                   frame_done_q, frame_done_d;

  // Frame bookkeeping
  logic [SEGMENT_NUMBER_MAX-1:0] bitmap_q, bitmap_d;
  logic [15:0]                   count_q,  count_d;

  // Helper signals
  logic                 commit_req;
  logic [23:0]          hdr_start;
  logic                 seg_in_range;
  logic [SEG_IDX_W-1:0] seg_idx;
  logic                 hdr_dup;
  logic                 hdr_bad;
  logic [23:0]          pixaddr_inc;

  // The last header byte completes startaddr; validate on the fly
  assign hdr_start    = {start_q[15:0], rx_data};
  assign seg_in_range = (seg_q < 16'(SEGMENT_NUMBER_MAX));
  assign seg_idx      = seg_q[SEG_IDX_W-1:0];
  assign hdr_dup      = seg_in_range && bitmap_q[seg_idx];
  assign hdr_bad      = (txid_q == 8'd0) || (txid_q > redundancy) || !seg_in_range ||
                        (hdr_start >= 24'(MAX_VRAMADDR));
  assign pixaddr_inc  = (pixaddr_q + 24'd1 == 24'(MAX_VRAMADDR)) ? 24'd0 : pixaddr_q + 24'd1;

  // Parser FSM: header capture, pixel packing and VRAM write generation
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    txid_d      = txid_q;
    seg_d       = seg_q;
    start_d     = start_q;
    phase_d     = phase_q;
    r_d         = r_q;
    g_d         = g_q;
    pixaddr_d   = pixaddr_q;
    pix_cnt_d   = pix_cnt_q;
    vram_we_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    vram_din_d  = vram_din_q;
    dup_drop_d  = 1'b0;
    commit_req  = 1'b0;

    if (rx_valid && rx_sof) begin
      // A start-of-frame byte always begins a fresh header, aborting
      // whatever packet was in progress without committing it.
      txid_d    = rx_data;
      hdr_cnt_d = 3'd1;
      phase_d   = 2'd0;
      pix_cnt_d = '0;
      state_d   = HDR;
    end else begin
      unique case (state_q)
        IDLE: ;
        HDR: begin
          if (rx_valid) begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            case (hdr_cnt_q)
              3'd1, 3'd2: seg_d   = {seg_q[7:0], rx_data};
              3'd3, 3'd4: start_d = {start_q[15:0], rx_data};
              default: begin
                start_d = hdr_start;
                if (hdr_bad || hdr_dup) begin
                  state_d    = DROP;
                  dup_drop_d = 1'b1;
                end else begin
                  state_d   = PIX;
                  pixaddr_d = hdr_start;
                  phase_d   = 2'd0;
                  pix_cnt_d = '0;
                end
              end
            endcase
          end
        end
        PIX: begin
          // Bytes past the pixel budget are ignored until end of packet
          if (rx_valid && (pix_cnt_q < PIX_CNT_W'(PAYLOAD_PIXELS))) begin
            case (phase_q)
              2'd0: begin
                r_d     = rx_data;
                phase_d = 2'd1;
              end
              2'd1: begin
                g_d     = rx_data;
                phase_d = 2'd2;
              end
              default: begin
                vram_we_d   = 1'b1;
                vram_addr_d = pixaddr_q;
                vram_din_d  = {r_q, g_q, rx_data};
                pixaddr_d   = pixaddr_inc;
                pix_cnt_d   = pix_cnt_q + PIX_CNT_W'(1);
                phase_d     = 2'd0;
              end
            endcase
          end
        end
        DROP: ;
        default: state_d = IDLE;
      endcase
    end

    // End of packet wins over everything; a partial pixel is discarded.
    if (rx_eof) begin
      state_d = IDLE;
      phase_d = 2'd0;
    end
    commit_req = rx_eof && rx_crc_ok && (state_q == PIX) && !(rx_valid && rx_sof);
  end

  // Commit tracking: bitmap, committed count, frame completion and wrap
  always_comb begin
    bitmap_d     = bitmap_q;
    count_d      = count_q;
    seg_commit_d = 1'b0;
    frame_done_d = 1'b0;

    // The cycle after frame_done starts a fresh frame
    if (frame_done_q) begin
      bitmap_d = '0;
      count_d  = 16'd0;
    end

    if (commit_req) begin
      seg_commit_d = 1'b1;
      if (count_q + 16'd1 == 16'(SEGMENT_NUMBER_MAX)) begin
        // A full frame takes precedence over the segment-0 wrap rule
        bitmap_d[seg_idx] = 1'b1;
        count_d           = count_q + 16'd1;
        frame_done_d      = 1'b1;
      end else if ((seg_q == 16'd0) && (count_q != 16'd0)) begin
        // Segment 0 arriving mid-frame means the previous frame was lost
        bitmap_d    = '0;
        bitmap_d[0] = 1'b1;
        count_d     = 16'd1;
      end else begin
        bitmap_d[seg_idx] = 1'b1;
        count_d           = count_q + 16'd1;
      end
    end
  end

  // Parser and output registers
  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hdr_cnt_q    <= 3'd0;
      txid_q       <= 8'd0;
      seg_q        <= 16'd0;
      start_q      <= 24'd0;
      phase_q      <= 2'd0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      pixaddr_q    <= 24'd0;
      pix_cnt_q    <= '0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= 24'd0;
      vram_din_q   <= 24'd0;
      dup_drop_q   <= 1'b0;
      seg_commit_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values; blocking would create order-dependent races.
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      txid_q       <= txid_d;
      seg_q        <= seg_d;
      start_q      <= start_d;
      phase_q      <= phase_d;
      r_q          <= r_d;
      g_q          <= g_d;
      pixaddr_q    <= pixaddr_d;
      pix_cnt_q    <= pix_cnt_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_din_q   <= vram_din_d;
      dup_drop_q   <= dup_drop_d;
      seg_commit_q <= seg_commit_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Commit bitmap and counter registers
  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bitmap is a flop vector, not a RAM, so it can and must be
      // cleared by reset; the VRAM contents themselves are never reset.
      bitmap_q <= '0;
      count_q  <= 16'd0;
    end else begin
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
    end
  end

  assign vram_we         = vram_we_q;
  assign vram_addr       = vram_addr_q;
  assign vram_din        = vram_din_q;
  assign seg_commit      = seg_commit_q;
  assign dup_drop        = dup_drop_q;
  assign frame_done      = frame_done_q;
  assign committed_count = count_q;

endmodule

// File: tb/tb_rx_memory_control.sv
// Directed bench for rx_memory_control. Expected VRAM writes (address,
// data, due cycle) are queued as pixel bytes are driven and compared when
// the DUT asserts vram_we; pulse counts are compared after each packet.
module tb_rx_memory_control;

  logic        clk125MHz = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_sof = 1'b0;
  logic        rx_eof = 1'b0;
  logic        rx_crc_ok = 1'b0;
  logic [7:0]  redundancy = 8'd3;
  logic        vram_we;
  logic [23:0] vram_addr;
  logic [23:0] vram_din;
  logic        seg_commit;
  logic        dup_drop;
  logic        frame_done;
  logic [15:0] committed_count;

  rx_memory_control dut (
    .clk125MHz       (clk125MHz),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_sof          (rx_sof),
    .rx_eof          (rx_eof),
    .rx_crc_ok       (rx_crc_ok),
    .redundancy      (redundancy),
    .vram_we         (vram_we),
    .vram_addr       (vram_addr),
    .vram_din        (vram_din),
    .seg_commit      (seg_commit),
    .dup_drop        (dup_drop),
    .frame_done      (frame_done),
    .committed_count (committed_count)
  );

  always #4 clk125MHz = ~clk125MHz;

  int cyc = 0;
  always @(posedge clk125MHz) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int commit_seen = 0, drop_seen = 0, fdone_seen = 0, wr_seen = 0;
  int c0 = 0, d0 = 0, f0 = 0, w0 = 0;

  typedef struct {
    logic [23:0] addr;
    logic [23:0] din;
    int          due;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse monitor, sampled on the falling edge
  always @(negedge clk125MHz) begin
    if (rst_n) begin
      if (seg_commit) commit_seen++;
      if (dup_drop)   drop_seen++;
      if (frame_done) fdone_seen++;
      if (vram_we) begin
        wr_t e;
        wr_seen++;
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(vram_addr), 32'(e.addr));
          check("wr_data", 32'(vram_din), 32'(e.din));
          check("wr_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit sof, input bit eof, input bit crc);
    @(posedge clk125MHz);
    #1;
    rx_valid  = v;
    rx_data   = d;
    rx_sof    = sof;
    rx_eof    = eof;
    rx_crc_ok = crc;
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 5) == 0) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input logic [7:0] txid, input logic [15:0] seg, input logic [23:0] start,
                          input int npix, input int extra, input bit crc, input bit expect_wr,
                          input bit do_eof, input bit eof_last);
    logic [23:0] a;
    logic [7:0]  r, g, b;
    bit          eof_now, eof_sent;
    wr_t         e;
    a        = start;
    eof_sent = 1'b0;
    drive(1'b1, txid, 1'b1, 1'b0, 1'b0);
    maybe_gap(); drive(1'b1, seg[15:8], 1'b0, 1'b0, 1'b0);
    maybe_gap(); drive(1'b1, seg[7:0], 1'b0, 1'b0, 1'b0);
    maybe_gap(); drive(1'b1, start[23:16], 1'b0, 1'b0, 1'b0);
    maybe_gap(); drive(1'b1, start[15:8], 1'b0, 1'b0, 1'b0);
    maybe_gap(); drive(1'b1, start[7:0], 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < npix; j++) begin
      r = 8'(j) + txid;
      g = r + 8'd1;
      b = r + 8'd2;
      maybe_gap(); drive(1'b1, r, 1'b0, 1'b0, 1'b0);
      maybe_gap(); drive(1'b1, g, 1'b0, 1'b0, 1'b0);
      maybe_gap();
      eof_now = do_eof && eof_last && (extra == 0) && (j == npix - 1);
      drive(1'b1, b, 1'b0, eof_now, crc && eof_now);
      eof_sent = eof_sent | eof_now;
      if (expect_wr && j < 479) begin
        e.addr = a;
        e.din  = {r, g, b};
        e.due  = cyc + 1;
        exp_q.push_back(e);
        a = (a == 24'd57599) ? 24'd0 : a + 24'd1;
      end
    end
    for (int k = 0; k < extra; k++) begin
      maybe_gap(); drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    end
    if (do_eof && !eof_sent) begin
      maybe_gap(); drive(1'b0, 8'h00, 1'b0, 1'b1, crc);
    end
    if (do_eof) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mark();
    c0 = commit_seen;
    d0 = drop_seen;
    f0 = fdone_seen;
    w0 = wr_seen;
  endtask

  task automatic check_pkt(input string tag, input int exp_commit, input int exp_drop,
                           input int exp_wr, input int exp_fdone);
    repeat (3) @(negedge clk125MHz);
    check({tag, "_commit"}, 32'(commit_seen - c0), 32'(exp_commit));
    check({tag, "_drop"},   32'(drop_seen - d0),   32'(exp_drop));
    check({tag, "_writes"}, 32'(wr_seen - w0),     32'(exp_wr));
    check({tag, "_fdone"},  32'(fdone_seen - f0),  32'(exp_fdone));
    check({tag, "_drain"},  32'(exp_q.size()),     32'd0);
  endtask

  // Absolute time limit so the run always terminates
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk125MHz);
    check("rst_vram_we", 32'(vram_we), 32'd0);
    check("rst_vram_addr", 32'(vram_addr), 32'd0);
    check("rst_vram_din", 32'(vram_din), 32'd0);
    check("rst_seg_commit", 32'(seg_commit), 32'd0);
    check("rst_dup_drop", 32'(dup_drop), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_count", 32'(committed_count), 32'd0);
    rst_n = 1'b1;

    // Clean full-size packet
    mark(); send_pkt(8'd1, 16'd2, 24'd958, 479, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("clean", 1, 0, 479, 0);
    check("clean_count", 32'(committed_count), 32'd1);

    // Redundant copies of a good segment are dropped
    mark(); send_pkt(8'd1, 16'd5, 24'd300, 4, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("red_t1", 1, 0, 4, 0);
    mark(); send_pkt(8'd2, 16'd5, 24'd300, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pkt("red_t2", 0, 1, 0, 0);
    mark(); send_pkt(8'd3, 16'd5, 24'd300, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pkt("red_t3", 0, 1, 0, 0);
    check("red_count", 32'(committed_count), 32'd2);

    // First copy fails CRC: second copy writes and commits, third dropped
    mark(); send_pkt(8'd1, 16'd6, 24'd400, 4, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_pkt("crcbad_t1", 0, 0, 4, 0);
    mark(); send_pkt(8'd2, 16'd6, 24'd400, 4, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("crcbad_t2", 1, 0, 4, 0);
    mark(); send_pkt(8'd3, 16'd6, 24'd400, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pkt("crcbad_t3", 0, 1, 0, 0);
    check("crcbad_count", 32'(committed_count), 32'd3);

    // Address wrap at the end of VRAM
    mark(); send_pkt(8'd1, 16'd7, 24'd57599, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("addr_wrap", 1, 0, 3, 0);

    // Invalid headers
    mark(); send_pkt(8'd4, 16'd20, 24'd10, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pkt("bad_txid_hi", 0, 1, 0, 0);
    mark(); send_pkt(8'd0, 16'd20, 24'd10, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pkt("bad_txid_zero", 0, 1, 0, 0);
    mark(); send_pkt(8'd1, 16'd150, 24'd10, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pkt("bad_seg", 0, 1, 0, 0);
    mark(); send_pkt(8'd1, 16'd20, 24'd57600, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pkt("bad_start", 0, 1, 0, 0);

    // Truncated packet: three bytes then end of packet
    mark();
    drive(1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'd21, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_pkt("truncated", 0, 0, 0, 0);
    check("after_invalid_count", 32'(committed_count), 32'd4);

    // End of packet coinciding with the last B byte
    mark(); send_pkt(8'd1, 16'd8, 24'd5000, 5, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_pkt("eof_with_b", 1, 0, 5, 0);

    // Pixel budget: two surplus pixels are ignored
    mark(); send_pkt(8'd1, 16'd9, 24'd6000, 481, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("pix_limit", 1, 0, 479, 0);

    // Trailing partial pixel is discarded
    mark(); send_pkt(8'd1, 16'd10, 24'd7000, 2, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("partial", 1, 0, 2, 0);

    // New start-of-frame mid-packet aborts without commit
    mark();
    send_pkt(8'd1, 16'd11, 24'd1000, 10, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_pkt(8'd1, 16'd11, 24'd2000, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("sof_abort", 1, 0, 12, 0);
    check("sof_abort_count", 32'(committed_count), 32'd8);

    // Segment 0 of a new frame while the old one is incomplete
    mark(); send_pkt(8'd1, 16'd0, 24'd0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("frame_wrap", 1, 0, 1, 0);
    check("frame_wrap_count", 32'(committed_count), 32'd1);

    // Complete the frame with segments 1..149
    mark();
    for (int s = 1; s < 150; s++)
      send_pkt(8'd1, 16'(s), 24'(s * 3), 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk125MHz);
      if (frame_done) found = 1'b1;
    end
    check("frame_done_seen", 32'(found), 32'd1);
    check("frame_done_count", 32'(committed_count), 32'd150);
    @(negedge clk125MHz);
    check("frame_cleared_count", 32'(committed_count), 32'd0);
    check_pkt("frame_fill", 149, 0, 149, 1);

    // Segment 0 of the next frame is accepted again
    mark(); send_pkt(8'd1, 16'd0, 24'd500, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("next_frame", 1, 0, 2, 0);
    check("next_frame_count", 32'(committed_count), 32'd1);

    // Reset asserted while a write is on the outputs
    send_pkt(8'd1, 16'd1, 24'd700, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk125MHz);
    #1;
    check("pre_reset_we", 32'(vram_we), 32'd1);
    rx_valid  = 1'b0;
    rx_sof    = 1'b0;
    rx_eof    = 1'b0;
    rx_crc_ok = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_reset_we", 32'(vram_we), 32'd0);
    check("mid_reset_count", 32'(committed_count), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk125MHz);
    rst_n = 1'b1;

    // Parser recovers cleanly after reset
    mark(); send_pkt(8'd1, 16'd1, 24'd700, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pkt("post_reset", 1, 0, 2, 0);
    check("post_reset_count", 32'(committed_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
